// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset/lock sequencer with retry, fail and loss-of-lock tracking
module pll_reset_sequencer #(
    parameter int unsigned RESET_CYCLES        = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 64,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 4096,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic       clk,
    input  logic       aresetn,
    input  logic       pll_lock,
    input  logic       restart,
    output logic       pll_resetb,
    output logic       pll_bypass,
    output logic       core_resetn,
    output logic       locked,
    output logic       fail,
    output logic [3:0] retry_count,
    output logic [7:0] lol_count
);

    // One shared counter, sized for the longest wait of any state.
    localparam int unsigned CNT_MAX_A = (RESET_CYCLES > LOCK_STABLE_CYCLES) ? RESET_CYCLES : LOCK_STABLE_CYCLES;
    localparam int unsigned CNT_MAX   = (CNT_MAX_A > LOCK_TIMEOUT_CYCLES) ? CNT_MAX_A : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned CW        = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] RST_LAST = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    RETRY_LIM = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAIL
    } state_e;

    logic          rst_meta_q;
    logic          rst_sync_q;
    logic          rst_n;
    logic          lock_meta_q;
    logic          lock_s_q;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    retry_q, retry_d;
    logic [7:0]    lol_q, lol_d;
    logic          pll_resetb_q;
    logic          pll_bypass_q;
    logic          core_resetn_q;
    logic          locked_q;
    logic          fail_q;

    // Reset asserts immediately, releases two clk edges after aresetn rises.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    assign rst_n = rst_sync_q;

    // Two-flop synchronizer; only lock_s_q is used for decisions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock;
            lock_s_q    <= lock_meta_q;
        end
    end

    // Next-state logic; restart overrides every other transition.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        retry_d = retry_q;
        lol_d   = lol_q;
        if (restart) begin
            state_d = S_RESET_PLL;
            cnt_d   = '0;
            retry_d = 4'd0;
        end else begin
            case (state_q)
                S_RESET_PLL: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_s_q) begin
                        state_d = S_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TO_LAST) begin
                        retry_d = retry_q + 4'd1;
                        cnt_d   = '0;
                        state_d = (retry_d == RETRY_LIM) ? S_FAIL : S_RESET_PLL;
                    end
                end
                S_STABLE: begin
                    if (!lock_s_q) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STB_LAST) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                        retry_d = 4'd0;
                    end
                end
                S_RUN: begin
                    cnt_d = cnt_q;
                    if (!lock_s_q) begin
                        state_d = S_RESET_PLL;
                        cnt_d   = '0;
                        if (lol_q != 8'hFF) begin
                            lol_d = lol_q + 8'd1;
                        end
                    end
                end
                S_FAIL: begin
                    cnt_d = cnt_q;
                end
                default: begin
                    state_d = S_RESET_PLL;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, counters and outputs registered together; outputs decode the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_RESET_PLL;
            cnt_q         <= '0;
            retry_q       <= 4'd0;
            lol_q         <= 8'd0;
            pll_resetb_q  <= 1'b0;
            pll_bypass_q  <= 1'b0;
            core_resetn_q <= 1'b0;
            locked_q      <= 1'b0;
            fail_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retry_q       <= retry_d;
            lol_q         <= lol_d;
            pll_resetb_q  <= !(state_d == S_RESET_PLL || state_d == S_FAIL);
            pll_bypass_q  <= (state_d == S_FAIL);
            core_resetn_q <= (state_d == S_RUN);
            locked_q      <= (state_d == S_RUN);
            fail_q        <= (state_d == S_FAIL);
        end
    end

    assign pll_resetb  = pll_resetb_q;
    assign pll_bypass  = pll_bypass_q;
    assign core_resetn = core_resetn_q;
    assign locked      = locked_q;
    assign fail        = fail_q;
    assign retry_count = retry_q;
    assign lol_count   = lol_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - directed self-checking bench for pll_reset_sequencer
module tb_pll_reset_sequencer;

    logic       clk = 1'b0;
    logic       aresetn = 1'b1;
    logic       pll_lock = 1'b0;
    logic       restart = 1'b0;
    logic       pll_resetb;
    logic       pll_bypass;
    logic       core_resetn;
    logic       locked;
    logic       fail;
    logic [3:0] retry_count;
    logic [7:0] lol_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pll_reset_sequencer #(
        .RESET_CYCLES       (4),
        .LOCK_STABLE_CYCLES (8),
        .LOCK_TIMEOUT_CYCLES(32),
        .MAX_RETRIES        (2)
    ) dut (
        .clk        (clk),
        .aresetn    (aresetn),
        .pll_lock   (pll_lock),
        .restart    (restart),
        .pll_resetb (pll_resetb),
        .pll_bypass (pll_bypass),
        .core_resetn(core_resetn),
        .locked     (locked),
        .fail       (fail),
        .retry_count(retry_count),
        .lol_count  (lol_count)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait (at negedges) until the selected output equals val; ok=0 if budget expires.
    task automatic wait_sig(input int which, input logic val, input int budget, output bit ok);
        logic cur;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            case (which)
                0:       cur = pll_resetb;
                1:       cur = locked;
                2:       cur = fail;
                default: cur = (retry_count != 4'd0);
            endcase
            if (cur === val) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    task automatic test_reset;
        #1 aresetn = 1'b0;
        tick(3);
        n_cmp++; if (pll_resetb !== 1'b0) begin n_bad++; $display("FAIL reset_pll_resetb: got %b want 0", pll_resetb); end
        n_cmp++; if (pll_bypass !== 1'b0) begin n_bad++; $display("FAIL reset_pll_bypass: got %b want 0", pll_bypass); end
        n_cmp++; if (core_resetn !== 1'b0) begin n_bad++; $display("FAIL reset_core_resetn: got %b want 0", core_resetn); end
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked: got %b want 0", locked); end
        n_cmp++; if (fail !== 1'b0) begin n_bad++; $display("FAIL reset_fail: got %b want 0", fail); end
        n_cmp++; if (retry_count !== 4'd0) begin n_bad++; $display("FAIL reset_retry: got %0d want 0", retry_count); end
        n_cmp++; if (lol_count !== 8'd0) begin n_bad++; $display("FAIL reset_lol: got %0d want 0", lol_count); end
    endtask

    task automatic test_clean_lock;
        bit ok;
        aresetn = 1'b1;
        wait_sig(0, 1'b1, 30, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL clean_wait_resetb: got timeout want pll_resetb=1"); end
        pll_lock = 1'b1;
        tick(10);
        n_cmp++; if (core_resetn !== 1'b0) begin n_bad++; $display("FAIL clean_early_core: got %b want 0", core_resetn); end
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL clean_early_locked: got %b want 0", locked); end
        tick(1);
        n_cmp++; if (core_resetn !== 1'b1) begin n_bad++; $display("FAIL clean_core: got %b want 1", core_resetn); end
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL clean_locked: got %b want 1", locked); end
        n_cmp++; if (retry_count !== 4'd0) begin n_bad++; $display("FAIL clean_retry: got %0d want 0", retry_count); end
        n_cmp++; if (pll_bypass !== 1'b0) begin n_bad++; $display("FAIL clean_bypass: got %b want 0", pll_bypass); end
    endtask

    task automatic test_glitch;
        restart  = 1'b1;
        pll_lock = 1'b0;
        tick(1);
        restart = 1'b0;
        n_cmp++; if (pll_resetb !== 1'b0) begin n_bad++; $display("FAIL glitch_restart_resetb: got %b want 0", pll_resetb); end
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL glitch_restart_locked: got %b want 0", locked); end
        n_cmp++; if (lol_count !== 8'd0) begin n_bad++; $display("FAIL glitch_restart_lol: got %0d want 0", lol_count); end
        tick(3);
        n_cmp++; if (pll_resetb !== 1'b0) begin n_bad++; $display("FAIL glitch_resetb_4th: got %b want 0", pll_resetb); end
        tick(1);
        n_cmp++; if (pll_resetb !== 1'b1) begin n_bad++; $display("FAIL glitch_resetb_release: got %b want 1", pll_resetb); end
        pll_lock = 1'b1;
        tick(5);
        pll_lock = 1'b0;
        tick(1);
        pll_lock = 1'b1;
        tick(5);
        n_cmp++; if (core_resetn !== 1'b0) begin n_bad++; $display("FAIL glitch_core_held: got %b want 0", core_resetn); end
        n_cmp++; if (retry_count !== 4'd0) begin n_bad++; $display("FAIL glitch_retry: got %0d want 0", retry_count); end
        n_cmp++; if (pll_resetb !== 1'b1) begin n_bad++; $display("FAIL glitch_resetb_high: got %b want 1", pll_resetb); end
        tick(5);
        n_cmp++; if (core_resetn !== 1'b0) begin n_bad++; $display("FAIL glitch_core_pre: got %b want 0", core_resetn); end
        tick(1);
        n_cmp++; if (core_resetn !== 1'b1) begin n_bad++; $display("FAIL glitch_core_rise: got %b want 1", core_resetn); end
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL glitch_locked_rise: got %b want 1", locked); end
    endtask

    task automatic test_no_lock;
        bit ok;
        int n;
        restart  = 1'b1;
        pll_lock = 1'b0;
        tick(1);
        restart = 1'b0;
        wait_sig(3, 1'b1, 60, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL nolock_wait_retry: got timeout want retry_count=1"); end
        n_cmp++; if (retry_count !== 4'd1) begin n_bad++; $display("FAIL nolock_retry1: got %0d want 1", retry_count); end
        n_cmp++; if (fail !== 1'b0) begin n_bad++; $display("FAIL nolock_fail_early: got %b want 0", fail); end
        n = (pll_resetb === 1'b0) ? 1 : 0;
        while (pll_resetb === 1'b0 && n < 20) begin
            tick(1);
            if (pll_resetb === 1'b0) n++;
        end
        n_cmp++; if (n != 4) begin n_bad++; $display("FAIL nolock_reset_len: got %0d want 4", n); end
        tick(31);
        n_cmp++; if (fail !== 1'b0) begin n_bad++; $display("FAIL nolock_fail_pre_timeout: got %b want 0", fail); end
        tick(1);
        n_cmp++; if (fail !== 1'b1) begin n_bad++; $display("FAIL nolock_fail: got %b want 1", fail); end
        n_cmp++; if (retry_count !== 4'd2) begin n_bad++; $display("FAIL nolock_retry2: got %0d want 2", retry_count); end
        n_cmp++; if (pll_bypass !== 1'b1) begin n_bad++; $display("FAIL nolock_bypass: got %b want 1", pll_bypass); end
        n_cmp++; if (core_resetn !== 1'b0) begin n_bad++; $display("FAIL nolock_core: got %b want 0", core_resetn); end
        n_cmp++; if (pll_resetb !== 1'b0) begin n_bad++; $display("FAIL nolock_resetb: got %b want 0", pll_resetb); end
        pll_lock = 1'b1;
        tick(20);
        n_cmp++; if (fail !== 1'b1) begin n_bad++; $display("FAIL nolock_fail_hold: got %b want 1", fail); end
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL nolock_locked_hold: got %b want 0", locked); end
    endtask

    task automatic test_restart_fail;
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        n_cmp++; if (fail !== 1'b0) begin n_bad++; $display("FAIL rfail_fail: got %b want 0", fail); end
        n_cmp++; if (pll_bypass !== 1'b0) begin n_bad++; $display("FAIL rfail_bypass: got %b want 0", pll_bypass); end
        n_cmp++; if (retry_count !== 4'd0) begin n_bad++; $display("FAIL rfail_retry: got %0d want 0", retry_count); end
        n_cmp++; if (pll_resetb !== 1'b0) begin n_bad++; $display("FAIL rfail_resetb: got %b want 0", pll_resetb); end
        tick(3);
        n_cmp++; if (pll_resetb !== 1'b0) begin n_bad++; $display("FAIL rfail_resetb_4th: got %b want 0", pll_resetb); end
        tick(1);
        n_cmp++; if (pll_resetb !== 1'b1) begin n_bad++; $display("FAIL rfail_resetb_release: got %b want 1", pll_resetb); end
        tick(8);
        n_cmp++; if (core_resetn !== 1'b0) begin n_bad++; $display("FAIL rfail_core_pre: got %b want 0", core_resetn); end
        tick(1);
        n_cmp++; if (core_resetn !== 1'b1) begin n_bad++; $display("FAIL rfail_core: got %b want 1", core_resetn); end
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL rfail_locked: got %b want 1", locked); end
    endtask

    task automatic test_lol;
        bit ok;
        int exp_lol;
        for (int i = 1; i <= 300; i++) begin
            pll_lock = 1'b0;
            tick(3);
            exp_lol = (i > 255) ? 255 : i;
            n_cmp++; if (core_resetn !== 1'b0 || locked !== 1'b0) begin n_bad++; $display("FAIL lol_drop_%0d: got core=%b locked=%b want 0/0", i, core_resetn, locked); end
            n_cmp++; if (lol_count !== 8'(exp_lol)) begin n_bad++; $display("FAIL lol_count_%0d: got %0d want %0d", i, lol_count, exp_lol); end
            pll_lock = 1'b1;
            wait_sig(1, 1'b1, 40, ok);
            n_cmp++; if (!ok) begin n_bad++; $display("FAIL lol_relock_%0d: got timeout want locked=1", i); end
        end
        n_cmp++; if (lol_count !== 8'd255) begin n_bad++; $display("FAIL lol_saturated: got %0d want 255", lol_count); end
    endtask

    task automatic test_async_reset;
        bit ok;
        aresetn = 1'b0;
        tick(2);
        aresetn = 1'b1;
        wait_sig(1, 1'b1, 40, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL areset_relock: got timeout want locked=1"); end
        for (int i = 0; i < 5; i++) begin
            pll_lock = 1'b0;
            tick(3);
            pll_lock = 1'b1;
            wait_sig(1, 1'b1, 40, ok);
            n_cmp++; if (!ok) begin n_bad++; $display("FAIL areset_lol_relock_%0d: got timeout want locked=1", i); end
        end
        n_cmp++; if (lol_count !== 8'd5) begin n_bad++; $display("FAIL areset_lol5: got %0d want 5", lol_count); end
        #2 aresetn = 1'b0;
        #1;
        n_cmp++; if (pll_resetb !== 1'b0) begin n_bad++; $display("FAIL areset_resetb: got %b want 0", pll_resetb); end
        n_cmp++; if (pll_bypass !== 1'b0) begin n_bad++; $display("FAIL areset_bypass: got %b want 0", pll_bypass); end
        n_cmp++; if (core_resetn !== 1'b0) begin n_bad++; $display("FAIL areset_core: got %b want 0", core_resetn); end
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL areset_locked: got %b want 0", locked); end
        n_cmp++; if (fail !== 1'b0) begin n_bad++; $display("FAIL areset_fail: got %b want 0", fail); end
        n_cmp++; if (retry_count !== 4'd0) begin n_bad++; $display("FAIL areset_retry: got %0d want 0", retry_count); end
        n_cmp++; if (lol_count !== 8'd0) begin n_bad++; $display("FAIL areset_lol: got %0d want 0", lol_count); end
        tick(1);
        aresetn = 1'b1;
        tick(2);
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_glitch();
        test_no_lock();
        test_restart_fail();
        test_lol();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 16: number of cycles pll_resetb is held low on each PLL reset.
REQ-002 SHALL have parameter LOCK_STABLE_CYCLES, default 64: consecutive synchronised-lock cycles required before core release.
REQ-003 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 4096: maximum cycles spent waiting for lock per attempt.
REQ-004 SHALL have parameter MAX_RETRIES, default 3: number of failed lock attempts before FAIL.
REQ-005 SHALL have port clk, input, 1: the single clock, the PLL reference clock; all logic runs on it.
REQ-006 SHALL have port aresetn, input, 1: reset, asynchronous assert, active-low.
REQ-007 SHALL have port pll_lock, input, 1: PLL LOCK, asynchronous to clk.
REQ-008 SHALL have port restart, input, 1: single-cycle request to re-sequence from scratch.
REQ-009 SHALL have port pll_resetb, output, 1: drives PLL RESETB (low = PLL in reset).
REQ-010 SHALL have port pll_bypass, output, 1: drives PLL BYPASS.
REQ-011 SHALL have port core_resetn, output, 1: active-low reset for logic on the PLL output clock.
REQ-012 SHALL have port locked, output, 1: high only in RUN.
REQ-013 SHALL have port fail, output, 1: high only in FAIL.
REQ-014 SHALL have port retry_count, output, 4: failed attempts in the current sequence.
REQ-015 SHALL have port lol_count, output, 8: loss-of-lock events seen in RUN; saturates at 255.

Function
REQ-016 SHALL pass pll_lock through a 2-flop synchronizer, giving lock_s; all decisions SHALL use lock_s only.
REQ-017 SHALL register every output; no output SHALL depend combinationally on any input.
REQ-018 SHALL implement states RESET_PLL, WAIT_LOCK, STABLE, RUN and FAIL, with one shared cycle counter cleared on every state entry.
REQ-019 RESET_PLL: pll_resetb=0, core_resetn=0; after RESET_CYCLES cycles SHALL go to WAIT_LOCK.
REQ-020 WAIT_LOCK: pll_resetb=1, core_resetn=0; lock_s=1 SHALL go to STABLE.
REQ-021 WAIT_LOCK timeout: counter reaching LOCK_TIMEOUT_CYCLES with lock_s=0 SHALL increment retry_count.
REQ-022 After that increment, SHALL go to FAIL if the new retry_count equals MAX_RETRIES, else to RESET_PLL.
REQ-023 STABLE: any lock_s=0 cycle SHALL return to WAIT_LOCK with a fresh timeout and no retry increment.
REQ-024 STABLE: LOCK_STABLE_CYCLES consecutive lock_s=1 cycles SHALL go to RUN.
REQ-025 RUN: core_resetn=1, locked=1; retry_count SHALL clear on RUN entry.
REQ-026 RUN: lock_s=0 SHALL go to RESET_PLL, drive core_resetn=0 on that same registered edge, and increment lol_count with saturation.
REQ-027 FAIL: pll_resetb=0, pll_bypass=1, core_resetn=0, fail=1; FAIL SHALL be left only via restart or aresetn.
REQ-028 restart=1 in any state SHALL go to RESET_PLL on the next edge and clear retry_count; lol_count SHALL be preserved.
REQ-029 restart SHALL take priority over every other transition in the same cycle.
REQ-030 pll_bypass SHALL be 0 in every state except FAIL.
REQ-031 lock_s toggling during RESET_PLL SHALL be ignored.

Reset
REQ-032 aresetn low SHALL immediately force state RESET_PLL with counter 0.
REQ-033 aresetn low SHALL immediately force pll_resetb=0, pll_bypass=0, core_resetn=0, locked=0, fail=0, retry_count=0, lol_count=0 and synchronizer flops 0.
REQ-034 aresetn asserted mid-sequence, including in RUN or FAIL, SHALL behave identically to power-on reset.
REQ-035 Reset deassertion SHALL be synchronised to clk inside the block.

Verification (RESET_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2)
REQ-036 Clean lock: pll_lock rises with pll_resetb -> pll_resetb low exactly 4 cycles; core_resetn and locked rise 10 cycles after pll_lock first sampled high; retry_count=0.
REQ-037 Lock glitch: pll_lock drops for 1 cycle mid-STABLE -> return to WAIT_LOCK; stable count restarts; core_resetn stays 0; retry_count unchanged.
REQ-038 No lock: pll_lock held 0 -> two 4-cycle resets with retry_count 1 then 2; then fail=1, pll_bypass=1, core_resetn=0; holds until restart.
REQ-039 Loss of lock in RUN: pll_lock drops -> within 3 cycles core_resetn=0, locked=0, lol_count=1; full re-sequence follows; repeat 300 times -> lol_count=255.
REQ-040 restart in FAIL: -> RESET_PLL next cycle, retry_count=0, fail=0, pll_bypass=0; then relock as in REQ-036.
REQ-041 Async reset in RUN with lol_count=5: -> all outputs at reset values without a clk edge; lol_count=0.
